// File: rtl/mprjram_pkg.sv
// mprjram_pkg: shared types and constants for the user-project RAM arbiter
package mprjram_pkg;
  typedef enum logic [1:0] {IDLE, WB_WAIT, WB_ACK} state_t;
  typedef enum logic {GNT_WB, GNT_ACC} grant_t;
  localparam logic [7:0] MPRJRAM_PREFIX = 8'h38;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester not granted last wins
module rr_arb2
  import mprjram_pkg::*;
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_wb,
  input  logic       req_acc,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       last_grant
);
  grant_t last_q;
  assign last_grant = last_q;
  // bit 0 is WB, bit 1 is ACC; a tie goes to WB only if ACC won last time
  always_comb begin
    gnt = 2'b00;
    if (req_wb && (!req_acc || last_q == GNT_ACC)) gnt = 2'b01;
    else if (req_acc) gnt = 2'b10;
  end
  // remember the winner of every accepted grant
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) last_q <= GNT_ACC;
    else if (update && |gnt) last_q <= gnt[0] ? GNT_WB : GNT_ACC;
  end
endmodule

// File: rtl/mprjram_arbiter.sv
// mprjram_arbiter: shares one BRAM between delayed Wishbone accesses and a one-per-cycle accelerator port
module mprjram_arbiter
  import mprjram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DELAYS = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              acc_req_i,
  input  logic              acc_we_i,
  input  logic [3:0]        acc_be_i,
  input  logic [ADDR_W-1:0] acc_addr_i,
  input  logic [31:0]       acc_wdata_i,
  output logic              acc_gnt_o,
  output logic              acc_rvalid_o,
  output logic [31:0]       acc_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);
  localparam int CNT_W = (DELAYS > 1) ? $clog2(DELAYS) : 1;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0] gnt;
  logic last_grant, wb_hit, in_idle, rvalid_q, unused_ok;
  assign wb_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == MPRJRAM_PREFIX);
  assign in_idle = (state == IDLE) & ~wb_rst_i;
  assign unused_ok = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0], last_grant};
  assign acc_rvalid_o = rvalid_q;
  assign acc_rdata_o = rvalid_q ? ram_rdata_i : 32'h0;
  rr_arb2 u_arb (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .req_wb    (in_idle & wb_hit),
    .req_acc   (in_idle & acc_req_i),
    .update    (in_idle),
    .gnt       (gnt),
    .last_grant(last_grant)
  );
  // next state, delay counter and the RAM/bus muxes; RAM outputs stay 0 unless strobed
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    ram_en_o = 1'b0;
    ram_we_o = 4'h0;
    ram_addr_o = '0;
    ram_wdata_o = 32'h0;
    acc_gnt_o = 1'b0;
    wbs_ack_o = 1'b0;
    wbs_dat_o = 32'h0;
    case (state)
      IDLE: begin
        if (gnt[0]) begin
          state_nxt = WB_WAIT;
          cnt_nxt = CNT_W'(DELAYS - 1);
        end else if (gnt[1]) begin
          acc_gnt_o = 1'b1;
          ram_en_o = 1'b1;
          ram_we_o = acc_we_i ? acc_be_i : 4'h0;
          ram_addr_o = acc_addr_i;
          ram_wdata_o = acc_wdata_i;
        end
      end
      WB_WAIT: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else begin
          ram_en_o = 1'b1;
          ram_we_o = wbs_we_i ? wbs_sel_i : 4'h0;
          ram_addr_o = wbs_adr_i[ADDR_W+1:2];
          ram_wdata_o = wbs_dat_i;
          state_nxt = WB_ACK;
        end
      end
      WB_ACK: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = wbs_we_i ? 32'h0 : ram_rdata_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state, counter and the one-cycle-late accelerator read valid
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      rvalid_q <= acc_gnt_o & ~acc_we_i;
    end
  end
endmodule

// File: tb/tb_mprjram_arbiter.sv
// tb_mprjram_arbiter: directed vectors plus randomized traffic against a timestamp-based reference model
module tb_mprjram_arbiter;
  localparam int AW = 12;
  localparam int D = 10;
  logic clk = 0, rst = 1;
  logic wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [3:0] wbs_sel_i = 0;
  logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic acc_req_i = 0, acc_we_i = 0;
  logic [3:0] acc_be_i = 0;
  logic [AW-1:0] acc_addr_i = 0;
  logic [31:0] acc_wdata_i = 0;
  logic acc_gnt_o, acc_rvalid_o;
  logic [31:0] acc_rdata_o;
  logic ram_en_o;
  logic [3:0] ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0] ram_wdata_o, ram_rdata;
  logic [31:0] mem [4096];
  int pass_cnt = 0, tot_cnt = 0;

  always #5 clk = ~clk;

  mprjram_arbiter #(.ADDR_W(AW), .DELAYS(D)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .acc_req_i(acc_req_i), .acc_we_i(acc_we_i), .acc_be_i(acc_be_i),
    .acc_addr_i(acc_addr_i), .acc_wdata_i(acc_wdata_i),
    .acc_gnt_o(acc_gnt_o), .acc_rvalid_o(acc_rvalid_o), .acc_rdata_o(acc_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  // single-port BRAM, read-before-write, one cycle read latency
  always @(posedge clk) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++) if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata <= mem[ram_addr_o];
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic wb_idle();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  typedef struct {
    string name;
    logic [31:0] adr;
    logic we;
    logic [3:0] sel;
    logic [31:0] dat;
    logic [31:0] rd;
  } wb_vec_t;
  wb_vec_t vt[9];

  // one Wishbone transfer granted this cycle; strobe at +D, one-cycle ack at +D+1
  task automatic wb_xfer(wb_vec_t v);
    logic [AW-1:0] word;
    word = v.adr[AW+1:2];
    tick();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = v.we; wbs_sel_i = v.sel;
    wbs_adr_i = v.adr; wbs_dat_i = v.dat;
    for (int k = 0; k <= D + 1; k++) begin
      if (k > 0) tick();
      mid();
      chk({v.name, "_en_ack"}, {30'h0, ram_en_o, wbs_ack_o}, {30'h0, k == D, k == D + 1});
      if (k == D) begin
        chk({v.name, "_addr"}, 32'(ram_addr_o), 32'(word));
        chk({v.name, "_we"}, 32'(ram_we_o), 32'(v.we ? v.sel : 4'h0));
      end
      if (k == D + 1) chk({v.name, "_dat"}, wbs_dat_o, v.rd);
    end
    tick();
    wb_idle();
  endtask

  logic [31:0] ref_mem [int];
  logic [3:0] ref_kn [int];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{"wr_w4",     32'h3800_0010, 1'b1, 4'hF,    32'h0000_0028, 32'h0};
    vt[1] = '{"wr_w0_clr", 32'h3800_0000, 1'b1, 4'hF,    32'h0,         32'h0};
    vt[2] = '{"wr_w0_sel", 32'h3800_0000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0};
    vt[3] = '{"rd_w4",     32'h3800_0010, 1'b0, 4'hF,    32'h0,         32'h0000_0028};
    vt[4] = '{"rd_w0",     32'h3800_0000, 1'b0, 4'hF,    32'h0,         32'h0000_BEEF};
    vt[5] = '{"wr_top",    32'h3800_3FFC, 1'b1, 4'hF,    32'h1234_5678, 32'h0};
    vt[6] = '{"wr_top_b3", 32'h3800_3FFC, 1'b1, 4'b1000, 32'hAB00_0000, 32'h0};
    vt[7] = '{"rd_top",    32'h3800_3FFC, 1'b0, 4'hF,    32'h0,         32'hAB34_5678};
    vt[8] = '{"rd_alias",  32'h38FF_C010, 1'b0, 4'hF,    32'h0,         32'h0000_0028};

    // reset held three cycles, then every output idle
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mid();
    chk("rst_ack", wbs_ack_o, 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_gnt_rv", {acc_gnt_o, acc_rvalid_o}, 0);
    chk("rst_rdata", acc_rdata_o, 0);
    chk("rst_ram", {ram_en_o, ram_we_o, 16'(ram_addr_o)}, 0);
    chk("rst_wdata", ram_wdata_o, 0);

    // first tie after reset goes to WB, the following tie to ACC, the one after to WB
    tick();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3800_0014; wbs_dat_i = 32'h55;
    acc_req_i = 1; acc_we_i = 1; acc_be_i = 4'hF; acc_addr_i = 9; acc_wdata_i = 32'h99;
    for (int k = 0; k <= D + 3; k++) begin
      if (k > 0) tick();
      mid();
      chk("tie_acc_gnt", acc_gnt_o, k == D + 2);
      chk("tie_en_ack", {ram_en_o, wbs_ack_o}, {k == D || k == D + 2, k == D + 1});
      if (k == D + 2) chk("tie_acc_addr", 32'(ram_addr_o), 9);
    end
    tick();
    acc_req_i = 0;
    for (int j = 1; j <= D + 1; j++) begin
      if (j > 1) tick();
      mid();
      chk("tie2_en_ack", {ram_en_o, wbs_ack_o}, {j == D, j == D + 1});
    end
    tick();
    wb_idle();

    foreach (vt[i]) wb_xfer(vt[i]);

    // reset five cycles into a WB wait abandons the transfer
    tick();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3800_0010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) rst = 1;
      mid();
      chk("rstw_en_ack", {ram_en_o, wbs_ack_o}, 0);
    end
    tick();
    rst = 0;
    wb_idle();
    acc_req_i = 1; acc_we_i = 0; acc_addr_i = 4;
    mid();
    chk("rstw_idle_gnt", acc_gnt_o, 1);
    tick();
    acc_req_i = 0;
    for (int k = 0; k <= D + 1; k++) begin
      if (k > 0) tick();
      mid();
      chk("rstw_no_ack", {ram_en_o, wbs_ack_o}, 0);
      if (k == 0) chk("rstw_rv_data", {acc_rvalid_o, acc_rdata_o[30:0]}, {1'b1, 31'h28});
    end

    // accesses outside the 0x38 window are ignored
    tick();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_0000;
    for (int k = 0; k <= D + 4; k++) begin
      if (k > 0) tick();
      mid();
      chk("nohit_en_ack", {ram_en_o, wbs_ack_o}, 0);
    end
    tick();
    wb_idle();

    // ACC writes then back-to-back reads of words 0..3
    for (int i = 0; i < 4; i++) begin
      tick();
      acc_req_i = 1; acc_we_i = 1; acc_be_i = 4'hF; acc_addr_i = AW'(i); acc_wdata_i = 32'hA0 + i;
      mid();
      chk("accw_gnt_we", {acc_gnt_o, ram_we_o}, 5'b11111);
    end
    for (int k = 0; k <= 4; k++) begin
      tick();
      acc_req_i = (k < 4); acc_we_i = 0; acc_addr_i = AW'(k);
      mid();
      if (k < 4) chk("accr_gnt", acc_gnt_o, 1);
      if (k == 0) chk("accw_no_rv", acc_rvalid_o, 0);
      else chk("accr_rv_data", {acc_rvalid_o, acc_rdata_o[30:0]}, {1'b1, 31'hA0 + 31'(k - 1)});
    end

    // randomized traffic against a timestamp reference model
    tick();
    acc_req_i = 0;
    rst = 1;
    tick();
    rst = 0;
    begin
      int free_at = 0, en_at = -1, ack_at = -1, ea;
      bit last_acc = 1, wb_act = 0, rv_exp = 0, rv_kn = 0, ack_kn = 0, g_acc, e_en, rk;
      logic [31:0] wb_adr = 0, wb_dat = 0, rv_dat = 0, ack_dat = 0, ewd, rv;
      logic wb_we = 0;
      logic [3:0] wb_sel = 0, ewe;
      for (int c = 0; c < 600; c++) begin
        tick();
        if (!wb_act && $urandom_range(0, 5) == 0) begin
          wb_act = 1;
          wb_adr = 32'h3800_0000 | ($urandom_range(0, 15) << 2);
          wb_we = 1'($urandom_range(0, 1));
          wb_sel = 4'($urandom);
          wb_dat = $urandom;
        end
        wbs_cyc_i = wb_act; wbs_stb_i = wb_act; wbs_we_i = wb_we;
        wbs_adr_i = wb_adr; wbs_sel_i = wb_sel; wbs_dat_i = wb_dat;
        acc_req_i = 1'($urandom_range(0, 1));
        acc_we_i = 1'($urandom_range(0, 1));
        acc_be_i = 4'($urandom);
        acc_addr_i = AW'($urandom_range(0, 15));
        acc_wdata_i = $urandom;
        g_acc = 0;
        if (c >= free_at) begin
          if (wb_act && (!acc_req_i || last_acc)) begin
            en_at = c + D; ack_at = c + D + 1; free_at = c + D + 2; last_acc = 0;
          end else if (acc_req_i) begin
            g_acc = 1; last_acc = 1;
          end
        end
        e_en = g_acc || c == en_at;
        ea = g_acc ? int'(acc_addr_i) : int'(wb_adr[AW+1:2]);
        ewe = g_acc ? (acc_we_i ? acc_be_i : 4'h0) : (wb_we ? wb_sel : 4'h0);
        ewd = g_acc ? acc_wdata_i : wb_dat;
        mid();
        chk("rnd_gnt", acc_gnt_o, g_acc);
        chk("rnd_en_ack", {ram_en_o, wbs_ack_o}, {e_en, c == ack_at});
        chk("rnd_rvalid", acc_rvalid_o, rv_exp);
        if (rv_exp && rv_kn) chk("rnd_acc_rdata", acc_rdata_o, rv_dat);
        if (c == ack_at && (wb_we || ack_kn)) chk("rnd_wb_dat", wbs_dat_o, wb_we ? 32'h0 : ack_dat);
        if (e_en) begin
          chk("rnd_ram_addr", 32'(ram_addr_o), 32'(ea));
          chk("rnd_ram_we", 32'(ram_we_o), 32'(ewe));
          if (ewe != 0) chk("rnd_ram_wdata", ram_wdata_o, ewd);
        end else chk("rnd_ram_idle", {ram_we_o, 16'(ram_addr_o)}, 0);
        if (e_en) begin
          rv = ref_mem.exists(ea) ? ref_mem[ea] : 32'h0;
          rk = ref_kn.exists(ea) && ref_kn[ea] == 4'hF;
          if (g_acc) begin rv_dat = rv; rv_kn = rk; end
          else begin ack_dat = rv; ack_kn = rk; end
          ref_mem[ea] = merge(rv, ewd, ewe);
          ref_kn[ea] = (ref_kn.exists(ea) ? ref_kn[ea] : 4'h0) | ewe;
        end
        rv_exp = g_acc && !acc_we_i;
        if (c == ack_at) wb_act = 0;
      end
    end
    tick();
    acc_req_i = 0;
    wb_idle();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
